// File: rtl/ccip_mem_responder.sv
// CCI-P style memory responder: zero-fills its line store, then serves
// reads at a fixed latency through a shift pipeline and acks writes.
//
// Parameters
//   ADDR_BITS  - implemented line-address bits (2^ADDR_BITS lines)
//   RD_LATENCY - cycles from read acceptance to c0 response (1..16)
//
// Ports
//   clk, reset                  - clock, async active-high reset
//   c0_req_valid/addr/mdata     - read request
//   c1_req_valid/addr/mdata/data - write request
//   c0_almfull, c1_almfull      - request back-pressure (high = drop)
//   c0_rsp_valid/mdata/data     - read response
//   c1_rsp_valid/mdata          - write ack
//   addr_err                    - sticky out-of-range address flag
//
// Optional feature: define CCIP_MEM_RESPONDER_ADDR_CHECK_EN to flag
// requests whose address bits above ADDR_BITS are nonzero. Without it
// upper address bits alias and addr_err is tied low.

module ccip_mem_responder #(
  parameter int ADDR_BITS  = 4,
  parameter int RD_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_req_valid,
  input  logic [41:0]  c0_req_addr,
  input  logic [15:0]  c0_req_mdata,
  input  logic         c1_req_valid,
  input  logic [41:0]  c1_req_addr,
  input  logic [15:0]  c1_req_mdata,
  input  logic [511:0] c1_req_data,
  output logic         c0_almfull,
  output logic         c1_almfull,
  output logic         c0_rsp_valid,
  output logic [15:0]  c0_rsp_mdata,
  output logic [511:0] c0_rsp_data,
  output logic         c1_rsp_valid,
  output logic [15:0]  c1_rsp_mdata,
  output logic         addr_err
);

  localparam int LINES = 1 << ADDR_BITS;

  typedef enum logic {CLEAR, READY} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_ptr_q, clr_ptr_d;

  logic                 rd_acc, wr_acc;
  logic                 rd_bad, wr_bad;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [511:0]         mem_wdata;
  logic [511:0]         rd_data;

  logic [511:0]         mem_q [LINES];

  logic [RD_LATENCY-1:0] pv_q;
  logic [15:0]           pm_q [RD_LATENCY];
  logic [511:0]          pd_q [RD_LATENCY];

  logic                 c1v_q;
  logic [15:0]          c1m_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_BITS'(1);
        if (&clr_ptr_q) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    c0_almfull = 1'b1;
    c1_almfull = 1'b1;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
      end
      READY: begin
        c0_almfull = 1'b0;
        c1_almfull = 1'b0;
        if (wr_acc && !wr_bad) begin
          mem_we    = 1'b1;
          mem_waddr = c1_req_addr[ADDR_BITS-1:0];
          mem_wdata = c1_req_data;
        end
      end
      default: ;
    endcase
  end

  assign rd_acc = c0_req_valid && !c0_almfull;
  assign wr_acc = c1_req_valid && !c1_almfull;

`ifdef CCIP_MEM_RESPONDER_ADDR_CHECK_EN
  logic addr_err_q;

  assign rd_bad = |c0_req_addr[41:ADDR_BITS];
  assign wr_bad = |c1_req_addr[41:ADDR_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      addr_err_q <= 1'b0;
    else if ((rd_acc && rd_bad) || (wr_acc && wr_bad))
      addr_err_q <= 1'b1;
  end

  assign addr_err = addr_err_q;
`else
  logic unused_hi;

  assign rd_bad    = 1'b0;
  assign wr_bad    = 1'b0;
  assign unused_hi = ^{c0_req_addr[41:ADDR_BITS],
                       c1_req_addr[41:ADDR_BITS]};
  assign addr_err  = 1'b0;
`endif

  // Combinational read before the edge gives read-before-write
  // ordering for a same-line read and write in one cycle.
  assign rd_data = rd_bad ? '0
                 : mem_q[c0_req_addr[ADDR_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------- read pipeline ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      for (int i = 1; i < RD_LATENCY; i++)
        pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pm_q[0] <= c0_req_mdata;
    pd_q[0] <= rd_data;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pm_q[i] <= pm_q[i-1];
      pd_q[i] <= pd_q[i-1];
    end
  end

  assign c0_rsp_valid = pv_q[RD_LATENCY-1];
  assign c0_rsp_mdata = c0_rsp_valid ? pm_q[RD_LATENCY-1] : '0;
  assign c0_rsp_data  = c0_rsp_valid ? pd_q[RD_LATENCY-1] : '0;

  // ---------------- write ack ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) c1v_q <= 1'b0;
    else       c1v_q <= wr_acc;
  end

  always_ff @(posedge clk) begin
    c1m_q <= c1_req_mdata;
  end

  assign c1_rsp_valid = c1v_q;
  assign c1_rsp_mdata = c1v_q ? c1m_q : '0;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Randomized and directed bench for ccip_mem_responder against a
// queue-based reference model of the line store and response timing.

module tb_ccip_mem_responder;

  localparam int AB    = 4;
  localparam int LAT   = 4;
  localparam int LINES = 1 << AB;

  logic         clk;
  logic         reset;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almfull;
  logic         c1_almfull;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         addr_err;

  ccip_mem_responder #(
    .ADDR_BITS (AB),
    .RD_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .c0_req_valid(c0_req_valid),
    .c0_req_addr (c0_req_addr),
    .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid),
    .c1_req_addr (c1_req_addr),
    .c1_req_mdata(c1_req_mdata),
    .c1_req_data (c1_req_data),
    .c0_almfull  (c0_almfull),
    .c1_almfull  (c1_almfull),
    .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_mdata(c0_rsp_mdata),
    .c0_rsp_data (c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid),
    .c1_rsp_mdata(c1_rsp_mdata),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [15:0]  md;
    logic [511:0] d;
  } rsp_t;

  typedef struct {
    int          due;
    logic [15:0] md;
  } ack_t;

  int n_chk;
  int n_err;
  int k;
  logic         err_exp;
  logic [511:0] mdl [LINES];
  rsp_t rq[$];
  ack_t aq[$];

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic is_bad(input logic [41:0] a);
`ifdef CCIP_MEM_RESPONDER_ADDR_CHECK_EN
    return |a[41:AB];
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic check_outputs();
    logic ev;
    chk("c0_almfull", c0_almfull, k < LINES);
    chk("c1_almfull", c1_almfull, k < LINES);
    chk("addr_err", addr_err, err_exp);
    ev = (rq.size() > 0) && (rq[0].due == k);
    chk("c0_valid", c0_rsp_valid, ev);
    if (ev) begin
      chk("c0_mdata", c0_rsp_mdata, rq[0].md);
      chk("c0_data", c0_rsp_data, rq[0].d);
      void'(rq.pop_front());
    end else begin
      chk("c0_idle_mdata", c0_rsp_mdata, 16'h0);
      chk("c0_idle_data", c0_rsp_data, 512'h0);
    end
    ev = (aq.size() > 0) && (aq[0].due == k);
    chk("c1_valid", c1_rsp_valid, ev);
    if (ev) begin
      chk("c1_mdata", c1_rsp_mdata, aq[0].md);
      void'(aq.pop_front());
    end
  endtask

  // One clock: check what the DUT shows now, drive the next request
  // pair, and fold accepted requests into the model.
  task automatic cycle(input logic         rv,
                       input logic [41:0]  ra,
                       input logic [15:0]  rm,
                       input logic         wv,
                       input logic [41:0]  wa,
                       input logic [15:0]  wm,
                       input logic [511:0] wd);
    rsp_t r;
    ack_t a;
    @(negedge clk);
    k++;
    check_outputs();
    c0_req_valid = rv;
    c0_req_addr  = ra;
    c0_req_mdata = rm;
    c1_req_valid = wv;
    c1_req_addr  = wa;
    c1_req_mdata = wm;
    c1_req_data  = wd;
    if (k >= LINES) begin
      if (rv) begin
        r.due = k + LAT;
        r.md  = rm;
        r.d   = is_bad(ra) ? '0 : mdl[ra[AB-1:0]];
        rq.push_back(r);
        if (is_bad(ra)) err_exp = 1'b1;
      end
      if (wv) begin
        a.due = k + 1;
        a.md  = wm;
        aq.push_back(a);
        if (is_bad(wa)) err_exp = 1'b1;
        else mdl[wa[AB-1:0]] = wd;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [41:0] a, input logic [15:0] m);
    cycle(1'b1, a, m, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [41:0] a, input logic [15:0] m,
                    input logic [511:0] d);
    cycle(1'b0, '0, '0, 1'b1, a, m, d);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
    #1;
    chk("rst_c0_valid", c0_rsp_valid, 1'b0);
    chk("rst_c1_valid", c1_rsp_valid, 1'b0);
    chk("rst_c0_almfull", c0_almfull, 1'b1);
    chk("rst_c1_almfull", c1_almfull, 1'b1);
    chk("rst_addr_err", addr_err, 1'b0);
    rq.delete();
    aq.delete();
    err_exp = 1'b0;
    for (int i = 0; i < LINES; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  logic [41:0]  ra, wa;
  logic [511:0] va, vb;

  initial begin
    n_chk        = 0;
    n_err        = 0;
    k            = 0;
    err_exp      = 1'b0;
    reset        = 1'b1;
    c0_req_valid = 1'b0;
    c0_req_addr  = '0;
    c0_req_mdata = '0;
    c1_req_valid = 1'b0;
    c1_req_addr  = '0;
    c1_req_mdata = '0;
    c1_req_data  = '0;

    do_reset();

    // Reads held high through CLEAR are dropped; first accepted one
    // (line 3) returns zeros.
    for (int i = 0; i < LINES + 2; i++) rd(42'd3, 16'(i));
    idle(LAT + 1);

    wr(42'd5, 16'h0011, 512'hDEAD_BEEF);
    idle(2);
    rd(42'd5, 16'h0022);
    idle(LAT + 1);

    // Back-to-back reads.
    for (int i = 0; i < 8; i++) wr(42'(i), 16'(i), rnd512());
    for (int i = 0; i < 8; i++) rd(42'(i), 16'(i));
    idle(LAT + 1);

    // Same-cycle read and write of one line: old data first.
    va = rnd512();
    vb = rnd512();
    wr(42'd2, 16'h0a0a, va);
    cycle(1'b1, 42'd2, 16'h0b0b, 1'b1, 42'd2, 16'h0c0c, vb);
    rd(42'd2, 16'h0d0d);
    idle(LAT + 1);

    // Out-of-range read address (aliases to line 0 unless checked).
    wr(42'd0, 16'h0e0e, rnd512());
    rd(42'h10, 16'h0f0f);
    idle(LAT + 1);

    // Reset while reads are in flight; assert it between edges while
    // a response is on the outputs.
    rd(42'd1, 16'h0101);
    rd(42'd2, 16'h0202);
    rd(42'd3, 16'h0303);
    idle(LAT - 2);
    idle(1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_c0_valid", c0_rsp_valid, 1'b0);
    do_reset();
    idle(LINES + LAT + 2);

    // Random traffic, including CLEAR-period drops and aliasing.
    for (int n = 0; n < 600; n++) begin
      ra = 42'($urandom_range(0, 7));
      wa = 42'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        ra[41:AB] = 38'({$urandom, $urandom}) | 38'd1;
      if ($urandom_range(0, 7) == 0)
        wa[41:AB] = 38'({$urandom, $urandom}) | 38'd1;
      cycle(1'($urandom), ra, 16'($urandom),
            1'($urandom), wa, 16'($urandom), rnd512());
      if (n == 300) do_reset();
    end
    idle(LAT + 2);
    chk("rsp_drained", 512'(rq.size()), 512'd0);
    chk("ack_drained", 512'(aq.size()), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
